ahb_single_master: RTL and testbench

- Command-driven AHB bus master that sits directly upstream of the GPIO/RAM slaves on the shared AHB fabric.
- Turns simple local read/write commands into AHB transfers of type NONSEQ, SINGLE burst, 32-bit size, one at a time (non-pipelined).
- Handles arbitration request/grant, slave wait states, the two-cycle ERROR response, and RETRY/SPLIT re-issue.
- Returns one response per command.

---
 rtl/ahb_single_master.sv | 179 +++++++++++++++++
 tb/tb_ahb_single_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_single_master.sv
// Command-driven, non-pipelined AHB master: one NONSEQ/SINGLE/word transfer per
// local command, with arbitration, wait states, ERROR, RETRY/SPLIT and data-phase timeout.
module ahb_single_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [31:0] rsp_rdata,
  output logic        HBUSREQ,
  input  logic        HGRANT,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t      state;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  retry_cnt;
  logic [7:0]  to_cnt;

  // Outcome of the finished transfer, published on rsp_* one cycle later.
  logic        res_error;
  logic        res_timeout;
  logic [31:0] res_rdata;

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign cmd_ready = (state == ST_IDLE) && !HRESET;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      retry_cnt   <= '0;
      to_cnt      <= '0;
      res_error   <= 1'b0;
      res_timeout <= 1'b0;
      res_rdata   <= '0;
      HBUSREQ     <= 1'b0;
      HTRANS      <= TRANS_IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_addr  <= cmd_addr & ~32'h3;
            lat_wdata <= cmd_wdata;
            retry_cnt <= '0;
            HBUSREQ   <= 1'b1;
            state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          HBUSREQ <= 1'b1;
          HTRANS  <= TRANS_IDLE;
          if (HGRANT && HREADY) begin
            HTRANS <= TRANS_NONSEQ;
            HADDR  <= lat_addr;
            HWRITE <= lat_write;
            state  <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (HREADY) begin
            HTRANS  <= TRANS_IDLE;
            HBUSREQ <= 1'b0;
            HWDATA  <= lat_write ? lat_wdata : 32'h0;
            to_cnt  <= '0;
            state   <= ST_DATA;
          end else if (!HGRANT) begin
            // Bus lost while the address phase was stalled: re-arbitrate.
            HTRANS <= TRANS_IDLE;
            state  <= ST_REQ;
          end
        end

        ST_DATA: begin
          if (HREADY) begin
            HWDATA <= '0;
            case (HRESP)
              RESP_OKAY: begin
                res_error   <= 1'b0;
                res_timeout <= 1'b0;
                res_rdata   <= lat_write ? 32'h0 : HRDATA;
                state       <= ST_RESP;
              end
              RESP_ERROR: begin
                res_error   <= 1'b1;
                res_timeout <= 1'b0;
                res_rdata   <= '0;
                state       <= ST_RESP;
              end
              default: begin
                // RETRY and SPLIT both re-issue the identical transfer.
                if (retry_cnt < RETRY_LIMIT) begin
                  retry_cnt <= retry_cnt + 4'd1;
                  HBUSREQ   <= 1'b1;
                  state     <= ST_REQ;
                end else begin
                  res_error   <= 1'b1;
                  res_timeout <= 1'b0;
                  res_rdata   <= '0;
                  state       <= ST_RESP;
                end
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            HWDATA      <= '0;
            res_error   <= 1'b0;
            res_timeout <= 1'b1;
            res_rdata   <= '0;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          rsp_valid   <= 1'b1;
          rsp_error   <= res_error;
          rsp_timeout <= res_timeout;
          rsp_rdata   <= res_rdata;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_single_master.sv
// Directed bench for ahb_single_master: scripted AHB slave/arbiter, bus monitor,
// and hand-computed expectations for latency, data, errors, retries, timeout and reset.
module tb_ahb_single_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        HBUSREQ;
  logic        HGRANT = 1'b0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_single_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .rsp_rdata(rsp_rdata),
    .HBUSREQ(HBUSREQ), .HGRANT(HGRANT), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scripted slave: data phase follows an accepted NONSEQ and lasts while HREADY is low.
  logic [1:0]  cfg_resp = 2'b00;
  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        dp;
  int          wcnt = 0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) dp <= 1'b0;
    else        dp <= (HTRANS == 2'b10 && HREADY) || (dp && !HREADY);
  end

  always @(negedge HCLK) begin
    if (!dp) begin
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0; wcnt = 0;
    end else if (cfg_resp != 2'b00) begin
      HREADY = (wcnt != 0); HRESP = cfg_resp; HRDATA = 32'h1234_5678; wcnt++;
    end else if (wcnt < cfg_waits) begin
      HREADY = 1'b0; HRESP = 2'b00; HRDATA = 32'hDEAD_BEEF; wcnt++;
    end else begin
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = cfg_rdata;
    end
  end

  // Bus monitor.
  int          cyc = 0, acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  int          nonseq_cnt = 0, ntrans_cyc = 0, hw_chg = 0;
  logic [31:0] m_haddr = '0, m_hwdata = '0, m_rdata = '0, hwdata_d = '0;
  logic        m_hwrite = 1'b0, m_err = 1'b0, m_to = 1'b0, dp_d = 1'b0;

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (HTRANS == 2'b10) begin
      ntrans_cyc <= ntrans_cyc + 1;
      m_haddr    <= HADDR;
      m_hwrite   <= HWRITE;
      if (HREADY) nonseq_cnt <= nonseq_cnt + 1;
    end
    if (dp) m_hwdata <= HWDATA;
    if (dp && dp_d && HWDATA != hwdata_d) hw_chg <= hw_chg + 1;
    dp_d     <= dp;
    hwdata_d <= HWDATA;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
      m_rdata <= rsp_rdata;
      m_err   <= rsp_error;
      m_to    <= rsp_timeout;
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int base);
    int n;
    n = 0;
    while (rsp_cnt == base && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check(tag, 32'(rsp_cnt - base), 32'd1);
  endtask

  // Response is sampled by the monitor on the edge after rsp_valid rises,
  // so a zero-wait command shows a monitor distance of 5 edges.
  int b_rsp, b_ns, b_tc, b_hw, bad;

  initial begin
    #1;
    check("rst_hbusreq", 32'(HBUSREQ), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("hsize", 32'(HSIZE), 32'd2);
    check("hburst", 32'(HBURST), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1 check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write then read, zero wait states.
    HGRANT = 1'b1; cfg_resp = 2'b00; cfg_waits = 0;
    b_rsp = rsp_cnt; b_tc = ntrans_cyc;
    send_cmd(1'b1, 32'h4, 32'h0000_00A5);
    wait_rsp("wr_rsp", b_rsp);
    check("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd5);
    check("wr_haddr", m_haddr, 32'h4);
    check("wr_hwrite", 32'(m_hwrite), 32'd1);
    check("wr_hwdata", m_hwdata, 32'h0000_00A5);
    check("wr_nonseq_cycles", 32'(ntrans_cyc - b_tc), 32'd1);
    check("wr_error", 32'(m_err), 32'd0);
    check("wr_rdata", m_rdata, 32'd0);
    repeat (3) @(negedge HCLK);
    check("wr_single_pulse", 32'(rsp_cnt - b_rsp), 32'd1);

    cfg_rdata = 32'h0000_00A5;
    b_rsp = rsp_cnt; b_tc = ntrans_cyc;
    send_cmd(1'b0, 32'h4, 32'hFFFF_FFFF);
    wait_rsp("rd_rsp", b_rsp);
    check("rd_latency", 32'(rsp_cyc - acc_cyc), 32'd5);
    check("rd_haddr", m_haddr, 32'h4);
    check("rd_hwrite", 32'(m_hwrite), 32'd0);
    check("rd_hwdata_zero", m_hwdata, 32'd0);
    check("rd_nonseq_cycles", 32'(ntrans_cyc - b_tc), 32'd1);
    check("rd_rdata", m_rdata, 32'h0000_00A5);
    check("rd_error", 32'(m_err), 32'd0);

    // Delayed grant; low address bits are dropped.
    @(negedge HCLK);
    HGRANT = 1'b0; cfg_rdata = 32'h0000_0011;
    b_rsp = rsp_cnt;
    send_cmd(1'b0, 32'h0000_000B, 32'h0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (HBUSREQ !== 1'b1 || HTRANS !== 2'b00) bad++;
      @(negedge HCLK);
    end
    check("grant_wait_bad_cycles", 32'(bad), 32'd0);
    HGRANT = 1'b1;
    @(negedge HCLK);
    check("grant_addr_htrans", 32'(HTRANS), 32'd2);
    check("grant_addr_aligned", HADDR, 32'h8);
    wait_rsp("grant_rsp", b_rsp);
    check("grant_rdata", m_rdata, 32'h0000_0011);

    // Three wait states on a read of 0x0.
    cfg_waits = 3; cfg_rdata = 32'h0000_0028;
    b_rsp = rsp_cnt; b_hw = hw_chg;
    send_cmd(1'b0, 32'h0, 32'h0);
    wait_rsp("wait_rsp", b_rsp);
    check("wait_latency", 32'(rsp_cyc - acc_cyc), 32'd8);
    check("wait_rdata", m_rdata, 32'h0000_0028);
    check("wait_hwdata_stable", 32'(hw_chg - b_hw), 32'd0);

    // Two-cycle ERROR response.
    cfg_waits = 0; cfg_resp = 2'b01;
    b_rsp = rsp_cnt; b_ns = nonseq_cnt;
    send_cmd(1'b0, 32'hC, 32'h0);
    wait_rsp("err_rsp", b_rsp);
    repeat (5) @(negedge HCLK);
    check("err_latency", 32'(rsp_cyc - acc_cyc), 32'd6);
    check("err_error", 32'(m_err), 32'd1);
    check("err_rdata", m_rdata, 32'd0);
    check("err_timeout", 32'(m_to), 32'd0);
    check("err_nonseq", 32'(nonseq_cnt - b_ns), 32'd1);

    // RETRY then SPLIT, never satisfied: initial try plus three re-issues.
    for (int k = 0; k < 2; k++) begin
      cfg_resp = (k == 0) ? 2'b10 : 2'b11;
      b_rsp = rsp_cnt; b_ns = nonseq_cnt;
      send_cmd(1'b0, 32'h10, 32'h0);
      wait_rsp("retry_rsp", b_rsp);
      repeat (3) @(negedge HCLK);
      check("retry_nonseq", 32'(nonseq_cnt - b_ns), 32'd4);
      check("retry_latency", 32'(rsp_cyc - acc_cyc), 32'd18);
      check("retry_haddr", m_haddr, 32'h10);
      check("retry_error", 32'(m_err), 32'd1);
      check("retry_rdata", m_rdata, 32'd0);
    end

    // Slave stuck with HREADY low: 16 stalled data cycles then timeout.
    cfg_resp = 2'b00; cfg_waits = 1000; cfg_rdata = 32'h0;
    b_rsp = rsp_cnt;
    send_cmd(1'b0, 32'h14, 32'h0);
    wait_rsp("to_rsp", b_rsp);
    check("to_latency", 32'(rsp_cyc - acc_cyc), 32'd20);
    check("to_timeout", 32'(m_to), 32'd1);
    check("to_error", 32'(m_err), 32'd0);
    check("to_rdata", m_rdata, 32'd0);
    @(negedge HCLK); HRESET = 1'b1;
    @(negedge HCLK); HRESET = 1'b0;

    // Reset asserted in the middle of a stalled write data phase.
    b_rsp = rsp_cnt;
    send_cmd(1'b1, 32'h18, 32'h5A5A_0001);
    repeat (2) @(negedge HCLK);
    check("mid_hwdata_before", HWDATA, 32'h5A5A_0001);
    HRESET = 1'b1;
    #1;
    check("mid_rst_hbusreq", 32'(HBUSREQ), 32'd0);
    check("mid_rst_htrans", 32'(HTRANS), 32'd0);
    check("mid_rst_haddr", HADDR, 32'd0);
    check("mid_rst_hwrite", 32'(HWRITE), 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge HCLK); HRESET = 1'b0;
    repeat (10) @(negedge HCLK);
    check("mid_rst_no_rsp", 32'(rsp_cnt - b_rsp), 32'd0);
    check("mid_rst_idle_ready", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
